// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Quotient feeds LO and remainder feeds HI. Produces one quotient bit per
// cycle, MSB first, on operand magnitudes, then applies the sign fix.
//
// Ports:
//   clk        clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   start      divide request, sampled only in IDLE
//   sign       1 = signed (DIV), 0 = unsigned (DIVU), captured with start
//   flush      cancel any operation (exception/eret flush)
//   dividend   GPR[rs], captured with start
//   divisor    GPR[rt], captured with start
//   busy       operation in progress (PREP, CALC, FIX); stalls the pipeline
//   done       one-cycle pulse, quotient/remainder valid
//   quotient   quotient to LO (holds until the next FIX)
//   remainder  remainder to HI (holds until the next FIX)
//
// Optional feature macro: DIV_EARLY_OUT_EN
//   When defined, PREP skips CALC if |divisor| > |dividend| or the dividend
//   is zero with a nonzero divisor. When undefined, no comparator is built.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_CALC = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             sign_reg;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic             neg_q;
    logic             neg_r;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   trial_c;
    logic             last_step_c;
    logic             early_out_c;

    // Operand magnitudes; negate only negative values of a signed divide
    assign a_mag_c = (sign_reg && a_reg[WIDTH-1]) ? (~a_reg + WIDTH'(1)) : a_reg;
    assign b_mag_c = (sign_reg && b_reg[WIDTH-1]) ? (~b_reg + WIDTH'(1)) : b_reg;

    // Trial subtract on the shifted remainder; the bit shifted out of the
    // remainder is kept as bit WIDTH so large divisors cannot overflow it
    assign trial_c = {rem, quo[WIDTH-1]} - {1'b0, b_mag};

    assign last_step_c = (cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
    assign early_out_c = (b_mag_c > a_mag_c) ||
                         ((a_mag_c == '0) && (b_mag_c != '0));
`else
    assign early_out_c = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_PREP;
            S_PREP:  state_next = early_out_c ? S_FIX : S_CALC;
            S_CALC:  if (last_step_c) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    // Registered status outputs, aligned with the state they describe
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == S_PREP) || (state_next == S_CALC) ||
                    (state_next == S_FIX);
            done <= (state_next == S_DONE);
        end
    end

    // Datapath: operand capture, magnitude prep, shift/subtract, sign fix
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sign_reg  <= 1'b0;
            b_mag     <= '0;
            rem       <= '0;
            quo       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (!flush) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg    <= dividend;
                        b_reg    <= divisor;
                        sign_reg <= sign;
                    end
                end
                S_PREP: begin
                    neg_q <= sign_reg & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    neg_r <= sign_reg & a_reg[WIDTH-1];
                    b_mag <= b_mag_c;
                    cnt   <= '0;
                    if (early_out_c) begin
                        quo <= '0;
                        rem <= a_mag_c;
                    end else begin
                        quo <= a_mag_c;
                        rem <= '0;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_W'(1);
                    if (!trial_c[WIDTH]) begin
                        rem <= trial_c[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= {rem[WIDTH-2:0], quo[WIDTH-1]};
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                end
                S_FIX: begin
                    // Divide-by-zero wins over the sign fix in both modes
                    if (b_reg == '0) begin
                        quotient  <= '1;
                        remainder <= a_reg;
                    end else begin
                        quotient  <= neg_q ? (~quo + WIDTH'(1)) : quo;
                        remainder <= neg_r ? (~rem + WIDTH'(1)) : rem;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (WIDTH = 32).
// Table vectors from hand-derived results, randomized operands checked
// against an arithmetic reference model, plus flush/reset/ignored-start
// sequences for the multi-cycle corner cases.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sign;
    logic        flush;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_vec;
    int n_miss;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sign      (sign),
        .flush     (flush),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model from plain 64-bit arithmetic (truncating division)
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, qq, rr, ma, mb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
        end
        lat = 35;
`ifdef DIV_EARLY_OUT_EN
        if ((mb > ma) || ((ma == 0) && (mb != 0))) lat = 3;
`endif
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Start one divide and follow it cycle by cycle; optionally present
    // extra start pulses in cycles 5 and 35 that must be ignored
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input int lat,
                          input bit inject, input string name);
        int done_cyc;
        int n_done;
        int busy_err;
        int last_cyc;
        done_cyc = 0;
        n_done   = 0;
        busy_err = 0;
        last_cyc = inject ? 40 : lat + 1;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sign     = s;
        step();
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            if (inject && (cyc == 5 || cyc == 35)) begin
                start    = 1'b1;
                dividend = 32'd5;
                divisor  = 32'd1;
                sign     = 1'b0;
            end else begin
                start    = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (busy !== (cyc < lat)) busy_err++;
            if (done === 1'b1) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            step();
        end
        start = 1'b0;
        check({name, " busy_profile_errors"}, 32'(busy_err), 32'd0);
        check({name, " done_cycle"}, 32'(done_cyc), 32'(lat));
        check({name, " done_pulses"}, 32'(n_done), 32'd1);
        check({name, " quotient"}, quotient, eq);
        check({name, " remainder"}, remainder, er);
        last_q = eq;
        last_r = er;
    endtask

    // Watch a number of cycles and return how many done pulses appeared
    task automatic count_done(input int ncyc, output int n);
        n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (done === 1'b1) n++;
            step();
        end
    endtask

    vec_t vecs[9];

    initial begin
        logic [31:0] mq, mr, ra, rb;
        logic        rs;
        int          lat;
        int          nd;

        n_vec    = 0;
        n_miss   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        flush    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{32'd100,       32'd7,         1'b0, 32'd14,        32'd2};
        vecs[1] = '{32'hFFFF_FF9C, 32'd7,         1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE};
        vecs[2] = '{32'd100,       32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2};
        vecs[3] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0};
        vecs[4] = '{32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'd0};
        vecs[5] = '{32'd123,       32'd0,         1'b0, 32'hFFFF_FFFF, 32'd123};
        vecs[6] = '{32'd123,       32'd0,         1'b1, 32'hFFFF_FFFF, 32'd123};
        vecs[7] = '{32'd5,         32'd9,         1'b0, 32'd0,         32'd5};
        vecs[8] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 32'd0,         32'hFFFF_FFFE};

        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        rst = 1'b0;
        step();

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            model(vecs[i].a, vecs[i].b, vecs[i].s, mq, mr, lat);
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, lat, 1'b0,
                   $sformatf("vec%0d", i));
        end

        // Extra starts in cycle 5 and in the DONE cycle are ignored
        model(32'd100, 32'd7, 1'b0, mq, mr, lat);
        run_op(32'd100, 32'd7, 1'b0, mq, mr, lat, 1'b1, "ignored_start");

        // Flush mid-calculation
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; sign = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy_cycle11", 32'(busy), 32'd0);
        count_done(40, nd);
        check("flush done_pulses", 32'(nd), 32'd0);
        check("flush quotient_held", quotient, last_q);
        check("flush remainder_held", remainder, last_r);
        run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 35, 1'b0, "after_flush");

        // flush and start together in IDLE: start is dropped
        start = 1'b1; flush = 1'b1; dividend = 32'd50; divisor = 32'd5; sign = 1'b0;
        step();
        start = 1'b0; flush = 1'b0;
        check("flush_start busy", 32'(busy), 32'd0);
        count_done(40, nd);
        check("flush_start done_pulses", 32'(nd), 32'd0);
        check("flush_start quotient_held", quotient, last_q);

        // Reset mid-calculation
        start = 1'b1; dividend = 32'd1000; divisor = 32'd3; sign = 1'b0;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst quotient", quotient, 32'd0);
        check("rst remainder", remainder, 32'd0);
        count_done(40, nd);
        check("rst done_pulses", 32'(nd), 32'd0);
        run_op(32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 35, 1'b0, "after_rst");

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = ra + 32'($urandom_range(0, 3));
                2: rb = ~32'($urandom_range(0, 15));
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'd0;
            model(ra, rb, rs, mq, mr, lat);
            run_op(ra, rb, rs, mq, mr, lat, 1'b0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
- Fed by the ID/EX pipeline register (start, operands, signedness). Quotient goes to LO and remainder to HI, through the HI/LO write path that feeds the EX/MEM register.
- Asserts busy so the hazard unit stalls PC, IF/ID and ID/EX while a divide is in flight.
- Cancelled by the exception/eret flush.

Parameters:
- WIDTH, 32, operand and result width in bits.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a divide; sampled only in IDLE
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start
- flush  input  1  cancel any operation (EX_Flush)
- dividend  input  WIDTH  GPR[rs], captured with start
- divisor  input  WIDTH  GPR[rt], captured with start
- busy  output  1  operation in progress (PREP, CALC, FIX)
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  quotient, to LO
- remainder  output  WIDTH  remainder, to HI

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, iteration counter=0, internal operand registers=0.
- Priority: rst > flush > normal operation.
- States:
  - IDLE: on start, latch dividend, divisor and sign; go to PREP. Otherwise stay.
  - PREP: one cycle. Form magnitudes: a value is two's-complement negated if sign=1 and its MSB=1. Record neg_q = sign & (dividend MSB ^ divisor MSB). Record neg_r = sign & dividend MSB. Clear counter and partial remainder. Go to CALC.
  - CALC: exactly WIDTH cycles, one quotient bit per cycle, MSB first.
    - Shift {partial remainder, quotient} left by 1.
    - Trial subtract divisor magnitude from the partial remainder.
    - If no borrow, keep the difference and set the quotient LSB to 1.
    - Counter width is clog2(WIDTH)+1. Leave CALC when counter == WIDTH-1 and the last step has been taken; go to FIX.
  - FIX: register the outputs.
    - quotient = neg_q ? -q : q
    - remainder = neg_r ? -r : r
    - Divide-by-zero overrides both modes: quotient = all ones, remainder = raw latched dividend.
    - Go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle; go to IDLE.
- Latency: start sampled at edge 0 gives PREP in cycle 1, CALC in cycles 2..WIDTH+1, FIX in cycle WIDTH+2, and done high in cycle WIDTH+3 (35 for WIDTH=32).
- busy is 1 in PREP, CALC and FIX. busy is 0 in IDLE and DONE; the hazard unit ORs start into its stall.
- Results hold after done until the next FIX. IDLE and flush leave them unchanged.
- start outside IDLE is ignored; no queueing. start during DONE is ignored; it is re-presented because the pipeline is still stalled one cycle.
- flush in any state: next state IDLE, busy=0, no done pulse, quotient/remainder unchanged. flush and start in the same IDLE cycle: start is dropped.
- rst mid-operation: all reset values next cycle, no done.
- Signed overflow 0x80000000 / -1: magnitude arithmetic is unsigned, so quotient = 0x80000000 and remainder = 0, with no exception.
- All arithmetic is WIDTH bits. The trial subtract is WIDTH+1 bits so the borrow is visible.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in PREP, if divisor magnitude > dividend magnitude, or the dividend is 0 (with a nonzero divisor), skip CALC.
  - Load q=0 and r=dividend magnitude, then go to FIX.
  - done is high in cycle 3 after the start edge.
  - Sign fix in FIX applies as normal.
- Undefined: every operation takes the full WIDTH+3 cycles; no comparator is built.

Test Plan:
- Unsigned: start, sign=0, 100 / 7 -> busy cycles 1-34, done only in cycle 35, quotient=14, remainder=2.
- Signed: -100 (0xFFFFFF9C) / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. Also 100 / -7 -> quotient=0xFFFFFFF2, remainder=2.
- Corners:
  - Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
  - Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
  - 123 / 0, either mode -> quotient=0xFFFFFFFF, remainder=123.
- Flush: start 1000/3, assert flush in cycle 10 -> busy=0 in cycle 11, no done, outputs keep old values. Then a fresh start 9/2 -> quotient=4, remainder=1 after 35 cycles. Repeat with rst instead of flush -> outputs return to 0.
- Ignored starts: extra start pulses in cycles 5 and 35 (DONE) -> no restart, single done pulse, result from the first operands.
- DIV_EARLY_OUT_EN defined: unsigned 5 / 9 -> done in cycle 3, quotient=0, remainder=5. Same stimulus with the macro undefined -> done in cycle 35, same result.
